// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM states and helpers for the UART TX and RX paths
package uart_pkg;

    // Both FSMs share this encoding; TX never enters WAIT_IDLE.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } uart_state_e;

    // Widest supported data field; parity helper works on a zero-extended word.
    localparam int MAX_DATA_BITS = 9;

    // Clocks per bit on the line.
    function automatic int uart_period(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    // Even parity is the XOR of the data bits; odd parity is its inverse.
    function automatic logic uart_parity(input logic [MAX_DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_if.sv
// rtl/uart_if.sv - user-side byte streams and error pulses of the UART
interface uart_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 rx_frame_err;
    logic                 rx_parity_err;
    logic                 rx_overrun;

    // User logic side.
    modport master (
        output tx_data, tx_valid, rx_ready,
        input  tx_ready, rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_overrun
    );

    // UART core side.
    modport slave (
        input  tx_data, tx_valid, rx_ready,
        output tx_ready, rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_overrun
    );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - RX synchroniser, deframing FSM and output register (parity via UART_PARITY_EN)
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ_HZ = 12000000,
    parameter int BAUD_RATE     = 9600,
    parameter int DATA_BITS     = 8,
    parameter int PARITY_ODD    = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_overrun
);
    localparam int PERIOD = uart_period(CLOCK_FREQ_HZ, BAUD_RATE);
    localparam int CW     = $clog2(PERIOD) + 1;

    logic                 rx_meta;
    logic                 rx_s;
    uart_state_e          state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [3:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 sample;
    logic                 deliver;
    logic                 frame_err_d;
    logic                 parity_err_d;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 frame_err_q;
    logic                 overrun_q;
`ifdef UART_PARITY_EN
    logic                 par_bad_q, par_bad_d;
    logic                 parity_err_q;
`endif

    // The counter reaches PERIOD-1 exactly at mid-bit once START has re-phased it.
    assign sample = (cnt_q == CW'(PERIOD - 1));

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // RX FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
`ifdef UART_PARITY_EN
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
`ifdef UART_PARITY_EN
            par_bad_q <= par_bad_d;
`endif
        end
    end

    // RX next-state: mid-bit sampling, stop check and error classification.
    always_comb begin
        state_d      = state_q;
        cnt_d        = sample ? '0 : cnt_q + CW'(1);
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        deliver      = 1'b0;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
`ifdef UART_PARITY_EN
        par_bad_d    = par_bad_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = cnt_q;
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = CW'(PERIOD - PERIOD / 2);
`ifdef UART_PARITY_EN
                    par_bad_d = 1'b0;
`endif
                end
            end
            START: begin
                if (sample) begin
                    state_d   = rx_s ? IDLE : DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (sample) begin
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    if (bit_idx_q == 4'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                if (sample) begin
                    par_bad_d = rx_s != uart_parity(MAX_DATA_BITS'(shift_q), 1'(PARITY_ODD));
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                if (sample) begin
                    if (!rx_s) begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_IDLE;
                    end
`ifdef UART_PARITY_EN
                    else if (par_bad_q) begin
                        parity_err_d = 1'b1;
                        state_d      = IDLE;
                    end
`endif
                    else begin
                        deliver = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                cnt_d = cnt_q;
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output holding register: keep an unaccepted byte, flag overrun on a new one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
            overrun_q   <= 1'b0;
            if (deliver) begin
                if (valid_q && !rx_ready) begin
                    overrun_q <= 1'b1;
                end else begin
                    data_q  <= shift_q;
                    valid_q <= 1'b1;
                end
            end else if (valid_q && rx_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

`ifdef UART_PARITY_EN
    // Parity error pulse lines up with the other error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end
    assign rx_parity_err = parity_err_q;
`else
    assign rx_parity_err = 1'b0;
`endif

    assign rx_data      = data_q;
    assign rx_valid     = valid_q;
    assign rx_frame_err = frame_err_q;
    assign rx_overrun   = overrun_q;

endmodule

// File: rtl/uart_core.sv
// rtl/uart_core.sv - full-duplex UART top: inline TX serialiser plus uart_rx (parity via UART_PARITY_EN)
module uart_core
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ_HZ = 12000000,
    parameter int BAUD_RATE     = 9600,
    parameter int DATA_BITS     = 8,
    parameter int STOP_BITS     = 1,
    parameter int PARITY_ODD    = 0
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  rx,
    output logic  tx,
    uart_if.slave bus
);
    localparam int PERIOD = uart_period(CLOCK_FREQ_HZ, BAUD_RATE);
    localparam int CW     = $clog2(PERIOD) + 1;

    uart_state_e          tx_state_q, tx_state_d;
    logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
    logic [3:0]           tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_q, tx_d;
    logic                 tx_bit_end;
    logic                 tx_last_stop;
    logic                 tx_accept;
`ifdef UART_PARITY_EN
    logic                 tx_par_q, tx_par_d;
`endif

    assign tx_bit_end   = (tx_cnt_q == CW'(PERIOD - 1));
    // Ready in the final cycle of the last stop bit lets frames run back-to-back.
    assign tx_last_stop = (tx_state_q == STOP) && (tx_bit_q == 4'(STOP_BITS - 1)) && tx_bit_end;
    assign bus.tx_ready = (tx_state_q == IDLE) || tx_last_stop;
    assign tx_accept    = bus.tx_valid && bus.tx_ready;
    assign tx           = tx_q;

    // TX FSM state register; async reset drives the line back to idle at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par_q   <= 1'b0;
`endif
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
`ifdef UART_PARITY_EN
            tx_par_q   <= tx_par_d;
`endif
        end
    end

    // TX next-state: tx_d is the line level for the cycle after this edge.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_bit_end ? '0 : tx_cnt_q + CW'(1);
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
`ifdef UART_PARITY_EN
        tx_par_d   = tx_par_q;
`endif
        case (tx_state_q)
            IDLE: begin
                tx_cnt_d = '0;
                tx_d     = 1'b1;
                if (tx_accept) begin
                    tx_state_d = START;
                    tx_shift_d = bus.tx_data;
                    tx_d       = 1'b0;
`ifdef UART_PARITY_EN
                    tx_par_d   = uart_parity(MAX_DATA_BITS'(bus.tx_data), 1'(PARITY_ODD));
`endif
                end
            end
            START: begin
                if (tx_bit_end) begin
                    tx_state_d = DATA;
                    tx_bit_d   = '0;
                    tx_d       = tx_shift_q[0];
                end
            end
            DATA: begin
                if (tx_bit_end) begin
                    if (tx_bit_q == 4'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
                        tx_state_d = PARITY;
                        tx_d       = tx_par_q;
`else
                        tx_state_d = STOP;
                        tx_d       = 1'b1;
`endif
                        tx_bit_d   = '0;
                    end else begin
                        tx_bit_d   = tx_bit_q + 4'd1;
                        tx_shift_d = tx_shift_q >> 1;
                        tx_d       = tx_shift_q[1];
                    end
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                if (tx_bit_end) begin
                    tx_state_d = STOP;
                    tx_bit_d   = '0;
                    tx_d       = 1'b1;
                end
            end
`endif
            STOP: begin
                if (tx_bit_end) begin
                    tx_bit_d = '0;
                    if (tx_bit_q != 4'(STOP_BITS - 1)) begin
                        tx_bit_d = tx_bit_q + 4'd1;
                    end else if (tx_accept) begin
                        tx_state_d = START;
                        tx_shift_d = bus.tx_data;
                        tx_d       = 1'b0;
`ifdef UART_PARITY_EN
                        tx_par_d   = uart_parity(MAX_DATA_BITS'(bus.tx_data), 1'(PARITY_ODD));
`endif
                    end else begin
                        tx_state_d = IDLE;
                        tx_d       = 1'b1;
                    end
                end
            end
            default: begin
                tx_state_d = IDLE;
                tx_cnt_d   = '0;
                tx_d       = 1'b1;
            end
        endcase
    end

    uart_rx #(
        .CLOCK_FREQ_HZ (CLOCK_FREQ_HZ),
        .BAUD_RATE     (BAUD_RATE),
        .DATA_BITS     (DATA_BITS),
        .PARITY_ODD    (PARITY_ODD)
    ) u_rx (
        .clk           (clk),
        .rst           (rst),
        .rx            (rx),
        .rx_data       (bus.rx_data),
        .rx_valid      (bus.rx_valid),
        .rx_ready      (bus.rx_ready),
        .rx_frame_err  (bus.rx_frame_err),
        .rx_parity_err (bus.rx_parity_err),
        .rx_overrun    (bus.rx_overrun)
    );

endmodule

// File: tb/tb_uart_core.sv
// tb/tb_uart_core.sv - directed self-checking bench for uart_core (PERIOD=10)
module tb_uart_core;
    localparam int PERIOD = 10;
`ifdef UART_PARITY_EN
    localparam int FRAME  = 11 * PERIOD;
    localparam logic PAR_ODD = 1'b0;
`else
    localparam int FRAME  = 10 * PERIOD;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx_drv = 1'b1;
    logic loop_en = 1'b0;
    logic tx;
    wire  rx_pin = loop_en ? tx : rx_drv;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fe_cnt = 0;
    int pe_cnt = 0;
    int ov_cnt = 0;
    logic [7:0] rx_q[$];

    uart_if #(.DATA_BITS(8)) bus ();

    uart_core #(
        .CLOCK_FREQ_HZ (1000),
        .BAUD_RATE     (100),
        .DATA_BITS     (8),
        .STOP_BITS     (1),
        .PARITY_ODD    (0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .rx  (rx_pin),
        .tx  (tx),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Collect accepted bytes and error pulses away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rx_valid && bus.rx_ready) rx_q.push_back(bus.rx_data);
            if (bus.rx_frame_err) fe_cnt++;
            if (bus.rx_parity_err) pe_cnt++;
            if (bus.rx_overrun) ov_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tx_send(input logic [7:0] b, output int t_acc);
        @(negedge clk);
        bus.tx_data  = b;
        bus.tx_valid = 1'b1;
        for (int i = 0; i < 400 && !bus.tx_ready; i++) @(negedge clk);
        check("tx_ready_wait", {31'd0, bus.tx_ready}, 32'd1);
        @(posedge clk);
        #1;
        t_acc = cyc;
        bus.tx_valid = 1'b0;
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (PERIOD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            repeat (PERIOD) @(negedge clk);
        end
`ifdef UART_PARITY_EN
        rx_drv = (^b) ^ PAR_ODD ^ par_flip;
        repeat (PERIOD) @(negedge clk);
`else
        if (par_flip) rx_drv = 1'b1;
`endif
        rx_drv = stop_bit;
        repeat (PERIOD) @(negedge clk);
    endtask

    task automatic wait_rx(input string tag, input int n);
        for (int i = 0; i < 600 && rx_q.size() < n; i++) @(negedge clk);
        check(tag, rx_q.size(), n);
    endtask

    task automatic set_rx_ready(input logic v);
        @(posedge clk);
        #1;
        bus.rx_ready = v;
    endtask

    initial begin
        int t0, t1, t2, ok, low, fe0, pe0, ov0;
        logic [9:0] exp_bits;
        bus.tx_data  = '0;
        bus.tx_valid = 1'b0;
        bus.rx_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_tx_ready", {31'd0, bus.tx_ready}, 32'd1);
        check("rst_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
        check("rst_rx_data", {24'd0, bus.rx_data}, 32'd0);
        check("rst_errs", {29'd0, bus.rx_frame_err, bus.rx_parity_err, bus.rx_overrun}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

`ifndef UART_PARITY_EN
        // 1. 8N1 frame of 0x35 on tx, ready low until the last stop cycle
        exp_bits = {1'b1, 8'h35, 1'b0};
        @(negedge clk);
        bus.tx_data  = 8'h35;
        bus.tx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.tx_valid = 1'b0;
        low = 0;
        for (int b = 0; b < 10; b++) begin
            ok = 0;
            for (int c = 0; c < PERIOD; c++) begin
                @(negedge clk);
                if (tx === exp_bits[b]) ok++;
                if (!bus.tx_ready) low++;
            end
            check($sformatf("tx35_bit%0d", b), ok, PERIOD);
        end
        check("tx35_ready_low", low, 99);
        check("tx35_ready_end", {31'd0, bus.tx_ready}, 32'd1);
        repeat (5) @(negedge clk);
`endif

        // 2. Loopback, back-to-back bytes
        fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt;
        rx_q.delete();
        loop_en = 1'b1;
        tx_send(8'h00, t0);
        tx_send(8'hFF, t1);
        tx_send(8'hA5, t2);
        check("b2b_gap1", t1 - t0, FRAME);
        check("b2b_gap2", t2 - t1, FRAME);
        wait_rx("loop_count", 3);
        if (rx_q.size() == 3) begin
            check("loop_b0", {24'd0, rx_q[0]}, 32'h00);
            check("loop_b1", {24'd0, rx_q[1]}, 32'hFF);
            check("loop_b2", {24'd0, rx_q[2]}, 32'hA5);
        end
        check("loop_errs", (fe_cnt - fe0) + (pe_cnt - pe0) + (ov_cnt - ov0), 0);
        repeat (20) @(negedge clk);
        loop_en = 1'b0;

        // 3. False start: 3 low cycles
        rx_q.delete();
        fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt;
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (3) @(negedge clk);
        rx_drv = 1'b1;
        repeat (30) @(negedge clk);
        check("fstart_no_valid", {31'd0, bus.rx_valid}, 32'd0);
        check("fstart_no_errs", (fe_cnt - fe0) + (pe_cnt - pe0) + (ov_cnt - ov0), 0);
        rx_frame(8'h5C, 1'b1, 1'b0);
        wait_rx("fstart_next_count", 1);
        if (rx_q.size() == 1) check("fstart_next_data", {24'd0, rx_q[0]}, 32'h5C);

        // 4. Stop bit low, line held low, then a good frame
        rx_q.delete();
        fe0 = fe_cnt; pe0 = pe_cnt;
        rx_frame(8'h41, 1'b0, 1'b0);
        repeat (50) @(negedge clk);
        rx_drv = 1'b1;
        repeat (20) @(negedge clk);
        check("brk_frame_err", fe_cnt - fe0, 1);
        check("brk_parity_err", pe_cnt - pe0, 0);
        check("brk_no_data", rx_q.size(), 0);
        rx_frame(8'h42, 1'b1, 1'b0);
        wait_rx("brk_next_count", 1);
        if (rx_q.size() == 1) check("brk_next_data", {24'd0, rx_q[0]}, 32'h42);
        check("brk_frame_err_total", fe_cnt - fe0, 1);

        // 5. Overrun with consumer stalled
        rx_q.delete();
        ov0 = ov_cnt;
        set_rx_ready(1'b0);
        rx_frame(8'h11, 1'b1, 1'b0);
        rx_frame(8'h22, 1'b1, 1'b0);
        repeat (20) @(negedge clk);
        check("ovr_valid", {31'd0, bus.rx_valid}, 32'd1);
        check("ovr_data_held", {24'd0, bus.rx_data}, 32'h11);
        check("ovr_pulses", ov_cnt - ov0, 1);
        set_rx_ready(1'b1);
        wait_rx("ovr_drain_count", 1);
        if (rx_q.size() == 1) check("ovr_drain_data", {24'd0, rx_q[0]}, 32'h11);
        @(negedge clk);
        check("ovr_valid_clear", {31'd0, bus.rx_valid}, 32'd0);

`ifdef UART_PARITY_EN
        // 6a. Parity bit of 0x07 (even) and RX parity error
        @(negedge clk);
        bus.tx_data  = 8'h07;
        bus.tx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.tx_valid = 1'b0;
        repeat (95) @(negedge clk);
        check("par_tx_bit", {31'd0, tx}, 32'd1);
        for (int i = 0; i < 200 && !bus.tx_ready; i++) @(negedge clk);
        rx_q.delete();
        fe0 = fe_cnt; pe0 = pe_cnt;
        rx_frame(8'h07, 1'b1, 1'b1);
        repeat (20) @(negedge clk);
        check("par_rx_err", pe_cnt - pe0, 1);
        check("par_rx_frame_err", fe_cnt - fe0, 0);
        check("par_rx_no_data", rx_q.size(), 0);
`endif

        // 6b. Reset mid-frame
        @(negedge clk);
        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.tx_valid = 1'b0;
        repeat (15) @(negedge clk);
        check("midrst_tx_before", {31'd0, tx}, 32'd0);
        rst = 1'b1;
        #1;
        check("midrst_tx", {31'd0, tx}, 32'd1);
        check("midrst_tx_ready", {31'd0, bus.tx_ready}, 32'd1);
        check("midrst_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rx_q.delete();
        loop_en = 1'b1;
        tx_send(8'h5A, t0);
        wait_rx("postrst_count", 1);
        if (rx_q.size() == 1) check("postrst_data", {24'd0, rx_q[0]}, 32'h5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog cycles=%0d limit=100000", cyc);
        $fatal(1, "watchdog");
    end

endmodule
